// File: rtl/npc_bpred.sv
// Next-PC generator for the MIPS IF stage: owns pcIF, predicts with a direct-mapped BTB of 2-bit counters,
// and redirects fetch when ID resolves a different PC. Define BPRED_STATS_EN to add ctrlCnt/mispCnt.
module npc_bpred #(
  parameter int          ENTRIES   = 16,
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [1:0]  CNT_ALLOC = 2'b10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        validID,
  input  logic [31:0] instrID,
  input  logic [31:0] pcID,
  input  logic [31:0] rsdataID,
  input  logic [31:0] rtdataID,
  output logic [31:0] pcIF,
  output logic [31:0] npc,
  output logic        predIF,
  output logic        flushIF
`ifdef BPRED_STATS_EN
  ,
  output logic [31:0] ctrlCnt,
  output logic [31:0] mispCnt
`endif
);

  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_JALR    = 6'h09;

  logic [ENTRIES-1:0] btb_valid;
  logic [TAG_W-1:0]   btb_tag    [ENTRIES];
  logic [31:0]        btb_target [ENTRIES];
  logic [1:0]         btb_cnt    [ENTRIES];

  // ID-stage decode and resolution
  logic [5:0]  op;
  logic [5:0]  funct;
  logic        is_beq;
  logic        is_bne;
  logic        is_cond;
  logic        is_jump;
  logic        is_jreg;
  logic        is_ctrl;
  logic        taken;
  logic [31:0] seq_id;
  logic [31:0] br_target;
  logic [31:0] jump_target;
  logic [31:0] taken_target;
  logic [31:0] actual;

  assign op          = instrID[31:26];
  assign funct       = instrID[5:0];
  assign is_beq      = (op == OP_BEQ);
  assign is_bne      = (op == OP_BNE);
  assign is_cond     = is_beq || is_bne;
  assign is_jump     = (op == OP_J) || (op == OP_JAL);
  assign is_jreg     = (op == OP_SPECIAL) && ((funct == FN_JR) || (funct == FN_JALR));
  assign is_ctrl     = is_cond || is_jump || is_jreg;
  assign seq_id      = pcID + 32'd4;
  assign br_target   = seq_id + {{14{instrID[15]}}, instrID[15:0], 2'b00};
  assign jump_target = {pcID[31:28], instrID[25:0], 2'b00};

  assign taken = (is_beq && (rsdataID == rtdataID)) ||
                 (is_bne && (rsdataID != rtdataID)) ||
                 is_jump || is_jreg;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    taken_target = rsdataID;
    if (is_cond)      taken_target = br_target;
    else if (is_jump) taken_target = jump_target;
  end

  assign actual = taken ? taken_target : seq_id;

  // IF-stage lookup
  logic [IDX-1:0]   if_idx;
  logic [TAG_W-1:0] if_tag;
  logic             if_hit;
  logic             mispredict;

  assign if_idx     = pcIF[IDX+1:2];
  assign if_tag     = pcIF[31:IDX+2];
  assign if_hit     = btb_valid[if_idx] && (btb_tag[if_idx] == if_tag);
  assign predIF     = if_hit && btb_cnt[if_idx][1];
  assign mispredict = validID && !stall && (pcIF != actual);
  assign flushIF    = mispredict;

  always_comb begin
    npc = pcIF + 32'd4;
    if (mispredict)  npc = actual;
    else if (predIF) npc = btb_target[if_idx];
  end

  // BTB training from the resolved ID instruction
  logic [IDX-1:0]   id_idx;
  logic [TAG_W-1:0] id_tag;
  logic             id_hit;
  logic [1:0]       id_cnt;
  logic             resolved;
  logic             btb_we;
  logic [1:0]       new_cnt;

  assign id_idx   = pcID[IDX+1:2];
  assign id_tag   = pcID[31:IDX+2];
  assign id_hit   = btb_valid[id_idx] && (btb_tag[id_idx] == id_tag);
  assign id_cnt   = btb_cnt[id_idx];
  assign resolved = validID && !stall && is_ctrl;
  assign btb_we   = resolved && (id_hit || taken);

  always_comb begin
    new_cnt = 2'b11;
    if (is_cond) begin
      if (!id_hit)     new_cnt = CNT_ALLOC;
      else if (taken)  new_cnt = (id_cnt == 2'b11) ? 2'b11 : id_cnt + 2'd1;
      else             new_cnt = (id_cnt == 2'b00) ? 2'b00 : id_cnt - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pcIF      <= RESET_PC;
      btb_valid <= '0;
    end else begin
      if (!stall) pcIF <= npc;
      if (btb_we) btb_valid[id_idx] <= 1'b1;
    end
  end

  // NOTE: only the valid bits are reset; tag/target/counter storage is qualified by valid and stays reset-free.
  always_ff @(posedge clk) begin
    if (btb_we) begin
      btb_tag[id_idx]    <= id_tag;
      btb_target[id_idx] <= taken_target;
      btb_cnt[id_idx]    <= new_cnt;
    end
  end

`ifdef BPRED_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrlCnt <= '0;
      mispCnt <= '0;
    end else begin
      if (resolved)   ctrlCnt <= ctrlCnt + 32'd1;
      if (mispredict) mispCnt <= mispCnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_npc_bpred.sv
// Self-checking bench for npc_bpred: directed predictor scenarios, then a randomized
// instruction stream checked every cycle against a behavioural BTB/fetch model.
module tb_npc_bpred;

  localparam int          ENTRIES  = 16;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] NOP      = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset, stall, validID;
  logic [31:0] instrID, pcID, rsdataID, rtdataID;
  logic [31:0] pcIF, npc;
  logic        predIF, flushIF;
`ifdef BPRED_STATS_EN
  logic [31:0] ctrlCnt, mispCnt;
`endif

  int checks = 0;
  int errors = 0;

  npc_bpred #(.ENTRIES(ENTRIES), .RESET_PC(RESET_PC), .CNT_ALLOC(2'b10)) dut (
    .clk(clk), .reset(reset), .stall(stall), .validID(validID),
    .instrID(instrID), .pcID(pcID), .rsdataID(rsdataID), .rtdataID(rtdataID),
    .pcIF(pcIF), .npc(npc), .predIF(predIF), .flushIF(flushIF)
`ifdef BPRED_STATS_EN
    , .ctrlCnt(ctrlCnt), .mispCnt(mispCnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] enc_br(input logic [5:0] op, input logic [15:0] imm);
    return {op, 5'd1, 5'd2, imm};
  endfunction
  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [31:0] tgt);
    return {op, tgt[27:2]};
  endfunction
  function automatic logic [31:0] enc_jr(input logic [5:0] fn);
    return {6'd0, 5'd1, 15'd0, fn};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic [31:0] rs, input logic [31:0] rt);
    validID = v; instrID = ins; pcID = pc; rsdataID = rs; rtdataID = rt;
  endtask

  // A non-control instruction at tgt-4 in ID forces fetch to tgt without touching the BTB.
  task automatic redirect(input logic [31:0] tgt);
    set_id(1'b1, NOP, tgt - 32'd4, 32'd0, 32'd0);
    tick;
    set_id(1'b0, NOP, 32'd0, 32'd0, 32'd0);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; stall = 1'b0;
    set_id(1'b0, NOP, 32'd0, 32'd0, 32'd0);
    tick; tick;
    reset = 1'b0;
    #1;
    checks++; if (pcIF !== 32'h3000) begin errors++; $display("FAIL reset_pc got %h want %h", pcIF, 32'h3000); end
    checks++; if (predIF !== 1'b0) begin errors++; $display("FAIL reset_pred got %b want 0", predIF); end
    checks++; if (flushIF !== 1'b0) begin errors++; $display("FAIL reset_flush got %b want 0", flushIF); end
    checks++; if (npc !== 32'h3004) begin errors++; $display("FAIL reset_npc got %h want %h", npc, 32'h3004); end
    tick; #1;
    checks++; if (pcIF !== 32'h3004) begin errors++; $display("FAIL seq_fetch1 got %h want %h", pcIF, 32'h3004); end
    tick; #1;
    checks++; if (pcIF !== 32'h3008) begin errors++; $display("FAIL seq_fetch2 got %h want %h", pcIF, 32'h3008); end
  endtask

  task automatic test_first_beq;
    tick;
    set_id(1'b1, enc_br(6'h04, 16'd4), 32'h3008, 32'd5, 32'd5);
    #1;
    checks++; if (flushIF !== 1'b1) begin errors++; $display("FAIL beq_first_flush got %b want 1", flushIF); end
    checks++; if (npc !== 32'h301C) begin errors++; $display("FAIL beq_first_npc got %h want %h", npc, 32'h301C); end
    tick;
    set_id(1'b0, NOP, 32'd0, 32'd0, 32'd0);
    #1;
    checks++; if (pcIF !== 32'h301C) begin errors++; $display("FAIL beq_first_pc got %h want %h", pcIF, 32'h301C); end
  endtask

  task automatic test_predict_taken;
    redirect(32'h3008);
    checks++; if (predIF !== 1'b1) begin errors++; $display("FAIL refetch_pred got %b want 1", predIF); end
    checks++; if (npc !== 32'h301C) begin errors++; $display("FAIL refetch_npc got %h want %h", npc, 32'h301C); end
    tick;
    set_id(1'b1, enc_br(6'h04, 16'd4), 32'h3008, 32'd7, 32'd7);
    #1;
    checks++; if (flushIF !== 1'b0) begin errors++; $display("FAIL taken_ok_flush got %b want 0", flushIF); end
    tick;
    set_id(1'b0, NOP, 32'd0, 32'd0, 32'd0);
  endtask

  task automatic beq_at_3008(input logic tk);
    set_id(1'b1, enc_br(6'h04, 16'd4), 32'h3008, 32'd1, tk ? 32'd1 : 32'd2);
  endtask

  task automatic test_not_taken;
    redirect(32'h3008);
    checks++; if (predIF !== 1'b1) begin errors++; $display("FAIL cnt3_pred got %b want 1", predIF); end
    tick; beq_at_3008(1'b0); #1;
    checks++; if (flushIF !== 1'b1) begin errors++; $display("FAIL nt1_flush got %b want 1", flushIF); end
    checks++; if (npc !== 32'h300C) begin errors++; $display("FAIL nt1_npc got %h want %h", npc, 32'h300C); end
    tick; set_id(1'b0, NOP, 32'd0, 32'd0, 32'd0);
    redirect(32'h3008);
    checks++; if (predIF !== 1'b1) begin errors++; $display("FAIL cnt2_pred got %b want 1", predIF); end
    tick; beq_at_3008(1'b0); #1;
    checks++; if (flushIF !== 1'b1) begin errors++; $display("FAIL nt2_flush got %b want 1", flushIF); end
    tick; set_id(1'b0, NOP, 32'd0, 32'd0, 32'd0);
    redirect(32'h3008);
    checks++; if (predIF !== 1'b0) begin errors++; $display("FAIL cnt1_pred got %b want 0", predIF); end
    checks++; if (npc !== 32'h300C) begin errors++; $display("FAIL cnt1_npc got %h want %h", npc, 32'h300C); end
    // Drive the counter to 0, try to push below 0, then one taken must leave it at 1 (not-taken).
    tick; beq_at_3008(1'b0); #1;
    checks++; if (flushIF !== 1'b0) begin errors++; $display("FAIL nt_correct_flush got %b want 0", flushIF); end
    tick; set_id(1'b0, NOP, 32'd0, 32'd0, 32'd0);
    redirect(32'h3008);
    tick; beq_at_3008(1'b0);
    tick; set_id(1'b0, NOP, 32'd0, 32'd0, 32'd0);
    redirect(32'h3008);
    tick; beq_at_3008(1'b1); #1;
    checks++; if (npc !== 32'h301C) begin errors++; $display("FAIL sat_taken_npc got %h want %h", npc, 32'h301C); end
    tick; set_id(1'b0, NOP, 32'd0, 32'd0, 32'd0);
    redirect(32'h3008);
    checks++; if (predIF !== 1'b0) begin errors++; $display("FAIL sat_low_pred got %b want 0", predIF); end
  endtask

  task automatic test_stall;
    stall = 1'b1;
    beq_at_3008(1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (pcIF !== 32'h3008) begin errors++; $display("FAIL stall_pc got %h want %h", pcIF, 32'h3008); end
      checks++; if (flushIF !== 1'b0) begin errors++; $display("FAIL stall_flush got %b want 0", flushIF); end
      checks++; if (npc !== 32'h300C) begin errors++; $display("FAIL stall_npc got %h want %h", npc, 32'h300C); end
      tick;
    end
    stall = 1'b0;
    #1;
    checks++; if (flushIF !== 1'b1) begin errors++; $display("FAIL unstall_flush got %b want 1", flushIF); end
    checks++; if (npc !== 32'h301C) begin errors++; $display("FAIL unstall_npc got %h want %h", npc, 32'h301C); end
    tick; set_id(1'b0, NOP, 32'd0, 32'd0, 32'd0); #1;
    checks++; if (pcIF !== 32'h301C) begin errors++; $display("FAIL unstall_pc got %h want %h", pcIF, 32'h301C); end
    // Counter should be 2 now (1 + one taken); a single not-taken drops it to weakly not-taken.
    redirect(32'h3008);
    checks++; if (predIF !== 1'b1) begin errors++; $display("FAIL stall_cnt2_pred got %b want 1", predIF); end
    tick; beq_at_3008(1'b0);
    tick; set_id(1'b0, NOP, 32'd0, 32'd0, 32'd0);
    redirect(32'h3008);
    checks++; if (predIF !== 1'b0) begin errors++; $display("FAIL stall_cnt1_pred got %b want 0", predIF); end
  endtask

  task automatic test_jr;
    set_id(1'b1, enc_jr(6'h08), 32'h3020, 32'h3100, 32'd0);
    #1;
    checks++; if (flushIF !== 1'b1) begin errors++; $display("FAIL jr_alloc_flush got %b want 1", flushIF); end
    checks++; if (npc !== 32'h3100) begin errors++; $display("FAIL jr_alloc_npc got %h want %h", npc, 32'h3100); end
    tick; set_id(1'b0, NOP, 32'd0, 32'd0, 32'd0);
    redirect(32'h3020);
    checks++; if (predIF !== 1'b1) begin errors++; $display("FAIL jr_pred got %b want 1", predIF); end
    checks++; if (npc !== 32'h3100) begin errors++; $display("FAIL jr_pred_npc got %h want %h", npc, 32'h3100); end
    tick;
    set_id(1'b1, enc_jr(6'h08), 32'h3020, 32'h3200, 32'd0);
    #1;
    checks++; if (flushIF !== 1'b1) begin errors++; $display("FAIL jr_tgt_flush got %b want 1", flushIF); end
    checks++; if (npc !== 32'h3200) begin errors++; $display("FAIL jr_tgt_npc got %h want %h", npc, 32'h3200); end
    tick; set_id(1'b0, NOP, 32'd0, 32'd0, 32'd0);
    redirect(32'h3020);
    checks++; if (npc !== 32'h3200) begin errors++; $display("FAIL jr_rewrite_npc got %h want %h", npc, 32'h3200); end
  endtask

  task automatic test_wrap;
    redirect(32'hFFFF_FFFC);
    checks++; if (npc !== 32'h0) begin errors++; $display("FAIL wrap_npc got %h want %h", npc, 32'h0); end
    tick; #1;
    checks++; if (pcIF !== 32'h0) begin errors++; $display("FAIL wrap_pc got %h want %h", pcIF, 32'h0); end
  endtask

  task automatic test_reset_mid;
    set_id(1'b1, enc_jr(6'h08), 32'h3040, 32'h3300, 32'd0);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    set_id(1'b0, NOP, 32'd0, 32'd0, 32'd0);
    #1;
    checks++; if (pcIF !== 32'h3000) begin errors++; $display("FAIL rst_mid_pc got %h want %h", pcIF, 32'h3000); end
    checks++; if (flushIF !== 1'b0) begin errors++; $display("FAIL rst_mid_flush got %b want 0", flushIF); end
    redirect(32'h3020);
    checks++; if (predIF !== 1'b0) begin errors++; $display("FAIL rst_mid_inval got %b want 0", predIF); end
    checks++; if (npc !== 32'h3024) begin errors++; $display("FAIL rst_mid_npc got %h want %h", npc, 32'h3024); end
  endtask

  // ---------------- behavioural reference model ----------------
  logic [31:0] imem [logic [31:0]];
  bit          m_v   [ENTRIES];
  logic [31:0] m_tag [ENTRIES];
  logic [31:0] m_tgt [ENTRIES];
  int          m_cnt [ENTRIES];

  function automatic int slot(input logic [31:0] pc);
    return int'((pc / 4) % ENTRIES);
  endfunction
  function automatic logic [31:0] tag_of(input logic [31:0] pc);
    return pc / (4 * ENTRIES);
  endfunction

  // Program region 0x3000..0x30FC; anything outside jumps back to its start.
  function automatic logic [31:0] fetch(input logic [31:0] pc);
    logic [31:0] tgt, d, ins;
    if (imem.exists(pc)) return imem[pc];
    tgt = 32'h3000 + 32'($urandom_range(0, 63)) * 4;
    d   = tgt - pc - 32'd4;
    if (pc < 32'h3000 || pc > 32'h30FC) ins = enc_j(6'h02, 32'h3000);
    else begin
      case ($urandom_range(0, 9))
        4:       ins = enc_br(6'h04, d[17:2]);
        5:       ins = enc_br(6'h05, d[17:2]);
        6:       ins = enc_j(6'h02, tgt);
        7:       ins = enc_j(6'h03, tgt);
        8:       ins = enc_jr(6'h08);
        9:       ins = enc_jr(6'h09);
        default: ins = {6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20};
      endcase
    end
    imem[pc] = ins;
    return ins;
  endfunction

  task automatic resolve(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] rs,
                         input logic [31:0] rt, output logic [31:0] act, output logic [31:0] tk_tgt,
                         output bit ctrl, output bit cond, output bit tk);
    int off;
    off = int'($signed(ins[15:0])) * 4;
    ctrl = 1'b1; cond = 1'b0; tk = 1'b1;
    case (ins[31:26])
      6'h04, 6'h05: begin
        cond   = 1'b1;
        tk     = (ins[31:26] == 6'h04) ? (rs == rt) : (rs != rt);
        tk_tgt = pc + 32'd4 + 32'(off);
      end
      6'h02, 6'h03: tk_tgt = {pc[31:28], ins[25:0], 2'b00};
      default: begin
        tk_tgt = rs;
        if (!(ins[31:26] == 6'd0 && (ins[5:0] == 6'h08 || ins[5:0] == 6'h09))) begin
          ctrl = 1'b0; tk = 1'b0;
        end
      end
    endcase
    act = tk ? tk_tgt : pc + 32'd4;
  endtask

  task automatic test_random;
    logic [31:0] m_pc, id_pc, id_ins, rs, rt, act, tk_tgt, e_npc, old_pc;
    bit          id_v, ctrl, cond, tk, e_pred, e_misp, hit;
    int          s, n_ctrl, n_misp;
    reset = 1'b1; stall = 1'b0;
    set_id(1'b0, NOP, 32'd0, 32'd0, 32'd0);
    tick;
    reset = 1'b0;
    for (int i = 0; i < ENTRIES; i++) m_v[i] = 1'b0;
    m_pc = RESET_PC; id_v = 1'b0; id_pc = 32'd0; id_ins = NOP;
    n_ctrl = 0; n_misp = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      stall = ($urandom_range(0, 7) == 0);
      if (id_ins[31:26] == 6'd0 && (id_ins[5:0] == 6'h08 || id_ins[5:0] == 6'h09)) begin
        rs = 32'h3000 + 32'($urandom_range(0, 63)) * 4; rt = 32'd0;
      end else begin
        rs = 32'($urandom_range(0, 1)); rt = 32'($urandom_range(0, 1));
      end
      set_id(id_v, id_ins, id_pc, rs, rt);
      #1;
      resolve(id_ins, id_pc, rs, rt, act, tk_tgt, ctrl, cond, tk);
      s      = slot(m_pc);
      e_pred = m_v[s] && (m_tag[s] == tag_of(m_pc)) && (m_cnt[s] >= 2);
      e_misp = id_v && !stall && (m_pc != act);
      e_npc  = e_misp ? act : (e_pred ? m_tgt[s] : m_pc + 32'd4);
      checks++; if (pcIF !== m_pc) begin errors++; $display("FAIL rnd_pc cyc %0d got %h want %h", cyc, pcIF, m_pc); end
      checks++; if (predIF !== e_pred) begin errors++; $display("FAIL rnd_pred cyc %0d got %b want %b", cyc, predIF, e_pred); end
      checks++; if (flushIF !== e_misp) begin errors++; $display("FAIL rnd_flush cyc %0d got %b want %b", cyc, flushIF, e_misp); end
      checks++; if (npc !== e_npc) begin errors++; $display("FAIL rnd_npc cyc %0d got %h want %h", cyc, npc, e_npc); end
      tick;
      if (!stall) begin
        if (id_v && ctrl) begin
          n_ctrl++;
          s   = slot(id_pc);
          hit = m_v[s] && (m_tag[s] == tag_of(id_pc));
          if (hit) begin
            if (!cond)   m_cnt[s] = 3;
            else if (tk) m_cnt[s] = (m_cnt[s] == 3) ? 3 : m_cnt[s] + 1;
            else         m_cnt[s] = (m_cnt[s] == 0) ? 0 : m_cnt[s] - 1;
            m_tgt[s] = tk_tgt;
          end else if (tk) begin
            m_v[s] = 1'b1; m_tag[s] = tag_of(id_pc); m_tgt[s] = tk_tgt;
            m_cnt[s] = cond ? 2 : 3;
          end
        end
        if (e_misp) n_misp++;
        old_pc = m_pc;
        m_pc   = e_npc;
        if (e_misp) id_v = 1'b0;
        else begin
          id_v = 1'b1; id_pc = old_pc; id_ins = fetch(old_pc);
        end
      end
    end
`ifdef BPRED_STATS_EN
    checks++; if (ctrlCnt !== 32'(n_ctrl)) begin errors++; $display("FAIL stats_ctrl got %0d want %0d", ctrlCnt, n_ctrl); end
    checks++; if (mispCnt !== 32'(n_misp)) begin errors++; $display("FAIL stats_misp got %0d want %0d", mispCnt, n_misp); end
`endif
  endtask

  initial begin
    test_reset;
    test_first_beq;
    test_predict_taken;
    test_not_taken;
    test_stall;
    test_jr;
    test_wrap;
    test_reset_mid;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
